// File: rtl/slow_mem_pkg.sv
// Shared types and line-interface widths for the slow memory responder.
package slow_mem_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/slow_mem_lat_ctr.sv
// Loadable down-counter used to time the request-to-response latency.
// cnt_one_o flags the final wait cycle so the responder can leave WAIT
// exactly LATENCY-1 cycles after the load.
module slow_mem_lat_ctr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         cnt_zero_o,
    output logic         cnt_one_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority over decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero_o = (cnt_q == '0);
    assign cnt_one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/slow_mem_responder.sv
// Fixed-latency line responder for the cache<->memory interface.
// Optional feature: define SLOW_MEM_STATS_EN to add rd_cnt/wr_cnt outputs
// counting completed reads and writes (saturating, cleared by rst).
module slow_mem_responder
    import slow_mem_pkg::*;
#(
    parameter int unsigned LINE_W     = slow_mem_pkg::LINE_W,
    parameter int unsigned ADDR_W     = slow_mem_pkg::ADDR_W,
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [LINE_W-1:0]     mem_wdata,
    output logic [LINE_W-1:0]     mem_rdata,
    output logic                  mem_ready,
    input  logic                  init_wen,
    input  logic [DEPTH_LOG2-1:0] init_addr,
    input  logic [LINE_W-1:0]     init_data,
    output logic                  busy,
    output logic                  proto_err
`ifdef SLOW_MEM_STATS_EN
    ,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]       wdata_q, wdata_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;
    logic                    proto_err_q, proto_err_d;
    logic [LINE_W-1:0]       mem_q [0:DEPTH-1];
    logic                    ctr_load, ctr_dec, cnt_zero, cnt_one;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    addr_hi_unused;

    // Upper line-address bits alias onto the stored lines.
    assign req_idx        = mem_addr[DEPTH_LOG2-1:0];
    assign addr_hi_unused = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

    slow_mem_lat_ctr #(
        .W (8)
    ) u_lat_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (8'(LATENCY - 1)),
        .dec_i      (ctr_dec),
        .cnt_zero_o (cnt_zero),
        .cnt_one_o  (cnt_one)
    );

    // Next-state, request latching and read-data capture on entry to RESP.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = '0;
        proto_err_d = proto_err_q | (mem_read & mem_write);
        ctr_load    = 1'b0;
        ctr_dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    op_d     = mem_write ? OP_WR : OP_RD;
                    addr_d   = req_idx;
                    wdata_d  = mem_wdata;
                    ctr_load = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        if (!mem_write) rdata_d = mem_q[req_idx];
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if ((op_q == OP_RD && !mem_read) || (op_q == OP_WR && !mem_write)) begin
                    state_d = IDLE;
                end else begin
                    ctr_dec = 1'b1;
                    // Counter holds the remaining wait cycles including this one.
                    if (cnt_one || cnt_zero) begin
                        state_d = RESP;
                        if (op_q == OP_RD) rdata_d = mem_q[addr_q];
                    end
                end
            end
            RESP: state_d = GAP;
            GAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Line storage (not reset): write commits at the end of RESP, preload only when idle.
    always_ff @(posedge clk) begin
        if (state_q == RESP && op_q == OP_WR) begin
            mem_q[addr_q] <= wdata_q;
        end else if (state_q == IDLE && init_wen && !(mem_read || mem_write)) begin
            mem_q[init_addr] <= init_data;
        end
    end

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;

`ifdef SLOW_MEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    // Completed-transaction counters, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if (op_q == OP_RD) begin
                if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 16'd1;
            end else begin
                if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule
